writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 162 ++++++++++++++++
 tb/tb_writeback_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: takes execute results, waits for load data, formats it and writes the register file.
// Latency: an ALU result accepted in cycle N is written in cycle N+1; load data seen in cycle M is written in M+1.
// Backpressure: in_ready is high only in IDLE; WAIT_MEM gives up after MEM_TIMEOUT cycles with no mem_valid.
//
// Ports:
//   clk, rst_n                     clock and async active-low reset
//   in_valid/in_ready              execute-result handshake
//   in_rd, in_reg_write,           destination register and write enable
//   in_mem_to_reg, in_funct3,      load select, load type
//   in_addr_lo, alu_result         load byte offset, execute result
//   mem_valid, load_data           raw little-endian load doubleword
//   RegWrite, write_reg,           register-file write port
//   write_data
//   wb_done, instret, err          retire pulse, retire count, sticky error
module writeback_stage #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic            in_mem_to_reg,
  input  logic [2:0]      in_funct3,
  input  logic [2:0]      in_addr_lo,
  input  logic [XLEN-1:0] alu_result,
  input  logic            mem_valid,
  input  logic [XLEN-1:0] load_data,
  output logic            RegWrite,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data,
  output logic            wb_done,
  output logic [63:0]     instret,
  output logic            err
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_e;

  state_e          state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [2:0]      addr_lo_q, addr_lo_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            suppress_q, suppress_d;
  logic            err_q, err_d;
  logic [63:0]     instret_q, instret_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  // Little-endian lane extraction; the lane index is the byte offset scaled to bits.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] d,
                                               input logic [2:0]      f3,
                                               input logic [2:0]      lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = d[{lo, 3'b000} +: 8];
    h = d[{lo[2:1], 4'b0000} +: 16];
    w = d[{lo[2], 5'b00000} +: 32];
    case (f3)
      3'b000:  fmt_load = {{(XLEN-8){b[7]}}, b};
      3'b100:  fmt_load = {{(XLEN-8){1'b0}}, b};
      3'b001:  fmt_load = {{(XLEN-16){h[15]}}, h};
      3'b101:  fmt_load = {{(XLEN-16){1'b0}}, h};
      3'b010:  fmt_load = {{(XLEN-32){w[31]}}, w};
      3'b110:  fmt_load = {{(XLEN-32){1'b0}}, w};
      3'b011:  fmt_load = d;
      default: fmt_load = '0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    data_d      = data_q;
    suppress_d  = suppress_q;
    err_d       = err_q;
    instret_d   = instret_q;
    tmo_d       = tmo_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rd_d        = in_rd;
          reg_write_d = in_reg_write;
          funct3_d    = in_funct3;
          addr_lo_d   = in_addr_lo;
          data_d      = alu_result;
          suppress_d  = 1'b0;
          tmo_d       = '0;
          state_d     = in_mem_to_reg ? WAIT_MEM : WRITE;
        end
      end
      WAIT_MEM: begin
        // Data arriving on the last allowed cycle still wins over the timeout.
        if (mem_valid) begin
          if (funct3_q == 3'b111) begin
            suppress_d = 1'b1;
            err_d      = 1'b1;
          end else begin
            data_d = fmt_load(load_data, funct3_q, addr_lo_q);
          end
          state_d = WRITE;
        end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
          suppress_d = 1'b1;
          err_d      = 1'b1;
          state_d    = WRITE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Count on entry to WRITE so instret already includes the retiring
    // instruction during its wb_done cycle.
    if (state_d == WRITE) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      data_q      <= '0;
      suppress_q  <= 1'b0;
      err_q       <= 1'b0;
      instret_q   <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      data_q      <= data_d;
      suppress_q  <= suppress_d;
      err_q       <= err_d;
      instret_q   <= instret_d;
      tmo_q       <= tmo_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign wb_done    = (state_q == WRITE);
  assign RegWrite   = wb_done && reg_write_q && (rd_q != 5'd0) && !suppress_q;
  assign write_reg  = rd_q;
  assign write_data = data_q;
  assign instret    = instret_q;
  assign err        = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus pushes expected writebacks,
// a negedge monitor pops and compares them whenever wb_done is seen.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [2:0]  in_funct3;
  logic [2:0]  in_addr_lo;
  logic [63:0] alu_result;
  logic        mem_valid;
  logic [63:0] load_data;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [63:0] write_data;
  logic        wb_done;
  logic [63:0] instret;
  logic        err;

  writeback_stage #(.XLEN(64), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .alu_result(alu_result),
    .mem_valid(mem_valid), .load_data(load_data),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .wb_done(wb_done), .instret(instret), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [63:0] ins;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_ins = 0;
  logic        exp_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every retire must match the oldest expectation; RegWrite never without wb_done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (RegWrite && !wb_done) chk("regwrite_outside_write", 64'(RegWrite), 64'd0);
      if (wb_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_wb_done", 64'(wb_done), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_regwrite", 64'(RegWrite), 64'(e.rw));
          chk("wb_write_reg", 64'(write_reg), 64'(e.rd));
          chk("wb_write_data", write_data, e.data);
          chk("wb_instret", instret, e.ins);
          chk("wb_err", 64'(err), 64'(e.err));
          chk("wb_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("wait_idle_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic issue(input logic m2r, input logic rw, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [2:0] lo, input logic [63:0] alu);
    wait_idle();
    in_valid = 1'b1; in_mem_to_reg = m2r; in_reg_write = rw; in_rd = rd;
    in_funct3 = f3; in_addr_lo = lo; alu_result = alu;
    @(posedge clk); #1;
    in_valid = 1'b0; in_mem_to_reg = 1'b0;
  endtask

  task automatic push(input logic rw, input logic [4:0] rd, input logic [63:0] d, input int c);
    exp_t e;
    exp_ins = exp_ins + 64'd1;
    e.rw = rw && (rd != 5'd0); e.rd = rd; e.data = d;
    e.ins = exp_ins; e.err = exp_err; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic alu_op(input logic rw, input logic [4:0] rd, input logic [63:0] a);
    issue(1'b0, rw, rd, 3'b000, 3'b000, a);
    push(rw, rd, a, cyc);
  endtask

  // Load: w wait cycles in WAIT_MEM, then one mem_valid beat; write lands the next cycle.
  task automatic load_op(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] lo,
                         input int w, input logic [63:0] ld, input logic [63:0] exp_d,
                         input logic illegal);
    issue(1'b1, 1'b1, rd, f3, lo, 64'hA5A5);
    chk("in_ready_wait_mem", 64'(in_ready), 64'd0);
    repeat (w) begin @(posedge clk); #1; end
    mem_valid = 1'b1; load_data = ld;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    if (illegal) exp_err = 1'b1;
    push(!illegal, rd, illegal ? 64'hA5A5 : exp_d, cyc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_wb_done", 64'(wb_done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_write_reg", 64'(write_reg), 64'd0);
    chk("rst_write_data", write_data, 64'd0);
    exp_ins = 0; exp_err = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0;
    in_mem_to_reg = 1'b0; in_funct3 = '0; in_addr_lo = '0; alu_result = '0;
    mem_valid = 1'b0; load_data = '0;
    #2;
    do_reset();

    // ALU writes
    alu_op(1'b1, 5'd5, 64'h1234);
    alu_op(1'b1, 5'd0, 64'hFF);
    alu_op(1'b0, 5'd7, 64'hABCD);

    // Loads: rd, funct3, addr_lo, wait cycles, raw data, expected
    load_op(5'd10, 3'b000, 3'd3, 4, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    load_op(5'd11, 3'b100, 3'd3, 4, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 1'b0);
    load_op(5'd12, 3'b110, 3'd4, 0, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_DEAD_BEEF, 1'b0);
    load_op(5'd13, 3'b010, 3'd4, 1, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0);
    load_op(5'd14, 3'b001, 3'd2, 2, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
    load_op(5'd15, 3'b101, 3'd6, 0, 64'h1234_0000_0000_0000, 64'h0000_0000_0000_1234, 1'b0);
    load_op(5'd16, 3'b011, 3'd5, 3, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0);
    load_op(5'd17, 3'b000, 3'd0, 0, 64'h0000_0000_0000_007F, 64'h0000_0000_0000_007F, 1'b0);
    load_op(5'd18, 3'b111, 3'd0, 1, 64'h1111_2222_3333_4444, 64'h0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end

    // Timeout: 16 WAIT_MEM cycles, then a suppressed retire with err set
    do_reset();
    issue(1'b1, 1'b1, 5'd13, 3'b011, 3'd0, 64'h55);
    c0 = cyc;
    exp_err = 1'b1;
    push(1'b0, 5'd13, 64'h55, c0 + 16);
    repeat (14) begin @(posedge clk); #1; end
    chk("err_before_timeout", 64'(err), 64'd0);
    repeat (6) begin @(posedge clk); #1; end
    mem_valid = 1'b1; load_data = 64'hFFFF;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("late_mem_valid_instret", instret, 64'd1);
    chk("late_mem_valid_data", write_data, 64'h55);
    chk("err_sticky", 64'(err), 64'd1);

    // Reset while waiting for memory abandons the load
    do_reset();
    issue(1'b1, 1'b1, 5'd9, 3'b011, 3'd0, 64'h77);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_regwrite", 64'(RegWrite), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_valid = 1'b1; load_data = 64'h9999;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_mid_instret", instret, 64'd0);
    chk("rst_mid_in_ready_after", 64'(in_ready), 64'd1);
    chk("rst_mid_err", 64'(err), 64'd0);

    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
